// File: rtl/video_palette_out_if.sv
// video_palette_out_if: byte stream carrying two 4-bit pixels per byte; master drives data/valid, slave returns ready
interface video_palette_out_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/video_palette_out.sv
// video_palette_out: nibble shifter + palette lookup + RRRGGGBB->RGB888 expansion with aligned syncs
// Ports: clk, reset_n (sync, active low), pix_ce/active/hsync_in/vsync_in from timing,
// bs (byte stream slave), pal_addr/pal_data to the palette RAM, red/green/blue/hsync_out/vsync_out/de_out
// to the encoder, underrun pulse. Define VIDEO_UNDERRUN_COUNT_EN to add a saturating underrun_count port.
module video_palette_out #(
  parameter logic [3:0] UNDERRUN_INDEX = 4'h0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  input  logic       active,
  input  logic       hsync_in,
  input  logic       vsync_in,
  video_palette_out_if.slave bs,
  output logic [3:0] pal_addr,
  input  logic [7:0] pal_data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic       underrun
`ifdef VIDEO_UNDERRUN_COUNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);
  typedef enum logic [1:0] {EMPTY, HI, LO} state_t;
  state_t state;
  logic       buf_valid;
  logic [7:0] buf_data;
  logic [3:0] lo_nib;
  logic       de1, hs1, vs1;
  logic       xfer, load, starve;
  logic [3:0] pix;
  assign bs.byte_ready = reset_n && !buf_valid;
  assign xfer   = bs.byte_valid && bs.byte_ready;
  assign load   = active && state != HI && buf_valid;
  assign starve = active && state != HI && !buf_valid;
  assign pix    = state == HI ? lo_nib : buf_valid ? buf_data[7:4] : UNDERRUN_INDEX;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= EMPTY;
      buf_valid <= 1'b0;
      buf_data  <= 8'h00;
      lo_nib    <= 4'h0;
      pal_addr  <= 4'h0;
      de1       <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= pix_ce && starve;
      // vsync resync wins over a same-clk transfer, which is dropped
      if (pix_ce && (vsync_in || load)) buf_valid <= 1'b0;
      else if (xfer) begin
        buf_valid <= 1'b1;
        buf_data  <= bs.byte_data;
      end
      if (pix_ce) begin
        state <= !active ? EMPTY : state == HI ? LO : buf_valid ? HI : EMPTY;
        if (load) lo_nib <= buf_data[3:0];
        if (active) pal_addr <= pix;
        de1       <= active;
        hs1       <= hsync_in;
        vs1       <= vsync_in;
        // pal_data has had at least one idle clk to settle since pal_addr moved
        red       <= de1 ? {pal_data[7:5], pal_data[7:5], pal_data[7:6]} : 8'h00;
        green     <= de1 ? {pal_data[4:2], pal_data[4:2], pal_data[4:3]} : 8'h00;
        blue      <= de1 ? {4{pal_data[1:0]}} : 8'h00;
        de_out    <= de1;
        hsync_out <= hs1;
        vsync_out <= vs1;
      end
    end
  end
`ifdef VIDEO_UNDERRUN_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) underrun_count <= 16'h0000;
    else if (pix_ce && starve && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'h0001;
  end
`endif
endmodule

// File: tb/tb_video_palette_out.sv
// tb_video_palette_out: directed self-checking bench for video_palette_out with a registered palette RAM model
module tb_video_palette_out;
  logic       clk = 1'b0;
  logic       reset_n, pix_ce, active, hsync_in, vsync_in;
  logic [3:0] pal_addr;
  logic [7:0] pal_data;
  logic [7:0] red, green, blue;
  logic       hsync_out, vsync_out, de_out, underrun;
  logic       und_seen, rdy_seen;
  logic [7:0] pal_mem [16];
  int checks = 0;
  int errors = 0;
`ifdef VIDEO_UNDERRUN_COUNT_EN
  logic [15:0] underrun_count;
`endif
  video_palette_out_if bif();
  video_palette_out #(.UNDERRUN_INDEX(4'h0)) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bs(bif),
    .pal_addr(pal_addr), .pal_data(pal_data),
    .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out), .underrun(underrun)
`ifdef VIDEO_UNDERRUN_COUNT_EN
    , .underrun_count(underrun_count)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) pal_data <= pal_mem[pal_addr];

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; pix_ce = 1'b0; active = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    bif.byte_valid = 1'b0; bif.byte_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pix(input logic a, input logic h, input logic v);
    @(negedge clk);
    active = a; hsync_in = h; vsync_in = v; pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0; und_seen = underrun; rdy_seen = bif.byte_ready;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    bif.byte_data = b; bif.byte_valid = 1'b1;
    while (!bif.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL push_timeout byte=%h ready stayed 0, required 1", b);
    end
    @(negedge clk);
    bif.byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pix_ce = 1'b0; active = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    bif.byte_valid = 1'b0; bif.byte_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bif.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bif.byte_ready); end
    checks++;
    if ({pal_addr, red, green, blue, hsync_out, vsync_out, de_out, underrun} !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {pal_addr, red, green, blue, hsync_out, vsync_out, de_out, underrun});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.byte_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b want=1", bif.byte_ready); end
  endtask

  task automatic test_stream();
    logic [28:0] exp_tab [6];
    logic        act_tab [6];
    int          unds = 0;
    exp_tab = '{{4'hA, 1'b0, 24'h000000}, {4'h5, 1'b1, 24'hFF00FF}, {4'h3, 1'b1, 24'h9292AA},
                {4'hC, 1'b1, 24'h00FF00}, {4'hC, 1'b1, 24'h0000FF}, {4'hC, 1'b0, 24'h000000}};
    act_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    push(8'hA5);
    for (int i = 0; i < 6; i++) begin
      pix(act_tab[i], 1'b0, 1'b0);
      unds += int'(und_seen);
      checks++;
      if ({pal_addr, de_out, red, green, blue} !== exp_tab[i]) begin
        errors++;
        $display("FAIL stream_step%0d got=%h want=%h", i, {pal_addr, de_out, red, green, blue}, exp_tab[i]);
      end
      if (i == 0) push(8'h3C);
    end
    checks++;
    if (unds != 0) begin errors++; $display("FAIL stream_underrun got=%0d want=0", unds); end
  endtask

  task automatic test_underrun();
    do_reset();
    push(8'h7E);
    pix(1'b1, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0);
    checks++;
    if (pal_addr !== 4'hE) begin errors++; $display("FAIL underrun_pre_addr got=%h want=e", pal_addr); end
    for (int i = 0; i < 3; i++) begin
      pix(1'b1, 1'b0, 1'b0);
      checks++;
      if ({pal_addr, und_seen, underrun} !== 6'b0000_10) begin
        errors++;
        $display("FAIL underrun_px%0d addr/pulse/after got=%b want=000010", i, {pal_addr, und_seen, underrun});
      end
    end
`ifdef VIDEO_UNDERRUN_COUNT_EN
    checks++;
    if (underrun_count !== 16'd3) begin errors++; $display("FAIL underrun_count got=%0d want=3", underrun_count); end
`endif
  endtask

  task automatic test_active_drop();
    do_reset();
    push(8'h12);
    pix(1'b1, 1'b0, 1'b0);
    push(8'h77);
    pix(1'b0, 1'b0, 1'b0);
    checks++;
    if ({pal_addr, de_out, red, green, blue} !== {4'h1, 1'b1, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL drop_hold got=%h want=%h", {pal_addr, de_out, red, green, blue}, {4'h1, 1'b1, 24'hFFFFFF});
    end
    checks++;
    if (rdy_seen !== 1'b0) begin errors++; $display("FAIL drop_buffer_kept ready got=%b want=0", rdy_seen); end
    pix(1'b0, 1'b0, 1'b0);
    checks++;
    if ({de_out, red, green, blue} !== 25'h0) begin
      errors++;
      $display("FAIL drop_blank got=%h want=0", {de_out, red, green, blue});
    end
    pix(1'b1, 1'b0, 1'b0);
    checks++;
    if ({pal_addr, und_seen} !== {4'h7, 1'b0}) begin
      errors++;
      $display("FAIL drop_next got=%h want=%h", {pal_addr, und_seen}, {4'h7, 1'b0});
    end
  endtask

  task automatic test_vsync();
    do_reset();
    push(8'h5A);
    checks++;
    if (bif.byte_ready !== 1'b0) begin errors++; $display("FAIL vsync_buf_full ready got=%b want=0", bif.byte_ready); end
    pix(1'b0, 1'b1, 1'b1);
    checks++;
    if (rdy_seen !== 1'b1) begin errors++; $display("FAIL vsync_ready got=%b want=1", rdy_seen); end
    pix(1'b0, 1'b0, 1'b0);
    checks++;
    if ({hsync_out, vsync_out} !== 2'b11) begin
      errors++;
      $display("FAIL sync_delay got=%b want=11", {hsync_out, vsync_out});
    end
    push(8'h3C);
    pix(1'b1, 1'b0, 1'b0);
    checks++;
    if (pal_addr !== 4'h3) begin errors++; $display("FAIL vsync_stale_hi got=%h want=3", pal_addr); end
    pix(1'b1, 1'b0, 1'b0);
    checks++;
    if (pal_addr !== 4'hC) begin errors++; $display("FAIL vsync_stale_lo got=%h want=c", pal_addr); end
  endtask

  task automatic test_midline_reset();
    do_reset();
    push(8'hA5);
    pix(1'b1, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0);
    checks++;
    if ({de_out, red} !== 9'h1FF) begin errors++; $display("FAIL midreset_pre got=%h want=1ff", {de_out, red}); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.byte_ready, pal_addr, de_out, red, green, blue} !== 30'h0) begin
      errors++;
      $display("FAIL midreset_clear got=%h want=0", {bif.byte_ready, pal_addr, de_out, red, green, blue});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.byte_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b want=1", bif.byte_ready); end
    pix(1'b1, 1'b0, 1'b0);
    checks++;
    if ({pal_addr, und_seen} !== {4'h0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_discard got=%h want=%h", {pal_addr, und_seen}, {4'h0, 1'b1});
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pal_mem[i] = 8'h00;
    pal_mem[4'hA] = 8'hE3;
    pal_mem[4'h5] = 8'h92;
    pal_mem[4'h3] = 8'h1C;
    pal_mem[4'hC] = 8'h03;
    pal_mem[4'h1] = 8'hFF;
    pal_mem[4'h7] = 8'hE0;
    test_reset();
    test_stream();
    test_underrun();
    test_active_drop();
    test_vsync();
    test_midline_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_palette_out.md
Name: video_palette_out

Overview:
- Read-side consumer of the 16-entry palette RAM.
- Accepts video-RAM bytes over a valid/ready stream. Each byte holds two 4-bit pixels, high nibble first.
- Drives the palette read address and expands the returned RRRGGGBB colour to 24-bit RGB.
- Delays HSYNC, VSYNC and DE to stay aligned with the colour. Sits between the video fetch logic and the display encoder.

Parameters:
- UNDERRUN_INDEX, 4'h0, palette index shown when no pixel data is available during active video.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- pix_ce  in  1  pixel clock enable; at least one idle clk between assertions
- active  in  1  display-enable from the timing generator, sampled on pix_ce
- hsync_in  in  1  horizontal sync, sampled on pix_ce
- vsync_in  in  1  vertical sync, sampled on pix_ce
- byte_data  in  8  two pixels: [7:4] first, [3:0] second
- byte_valid  in  1  byte_data valid
- byte_ready  out  1  block accepts byte this clk
- pal_addr  out  4  palette read address, registered
- pal_data  in  8  palette colour, valid 1 clk after pal_addr changes
- red  out  8  expanded red
- green  out  8  expanded green
- blue  out  8  expanded blue
- hsync_out  out  1  aligned hsync
- vsync_out  out  1  aligned vsync
- de_out  out  1  aligned display enable
- underrun  out  1  one-clk pulse per pixel substituted with UNDERRUN_INDEX

Behaviour:
- Reset (reset_n low at posedge clk):
  - pal_addr, red, green, blue, hsync_out, vsync_out, de_out, underrun all 0.
  - Shifter state EMPTY; prefetch buffer invalid.
  - byte_ready forced 0 while reset_n low.
  - Reset mid-line discards all held pixels.
- Prefetch buffer:
  - One byte deep. byte_ready = reset_n && !buf_valid.
  - Transfer on any clk with byte_valid && byte_ready, independent of pix_ce.
- Shifter FSM, states EMPTY, HI, LO. Advances only on pix_ce.
  - active=1, state EMPTY or LO, buf_valid=1: load byte from buffer, emit [7:4], go HI, buffer invalid. A same-clk transfer into the buffer is allowed.
  - active=1, state EMPTY or LO, buf_valid=0: emit UNDERRUN_INDEX, pulse underrun, go EMPTY.
  - active=1, state HI: emit low nibble, go LO.
  - active=0: go EMPTY. Partial byte (low nibble pending) is discarded; buffer is retained.
  - vsync_in=1 on pix_ce: also invalidate buffer (frame resync). A transfer in that same clk is dropped.
- Pipeline, 2 pix_ce ticks of latency:
  - Stage 1 registers pal_addr (held when active=0) plus de/hsync/vsync.
  - Stage 2, on the next pix_ce, captures pal_data and the delayed syncs. pal_data is already settled because of the pix_ce spacing rule.
- Colour expansion, pal_data = {R[2:0], G[2:0], B[1:0]}:
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
  - Examples: R=7 gives 8'hFF; R=0 gives 8'h00.
- Blanking: when stage-2 de is 0, red/green/blue are forced to 0.
- Outputs change only on clk edges where pix_ce=1, except underrun and byte_ready.

Optional Feature:
- Macro: VIDEO_UNDERRUN_COUNT_EN.
- Defined:
  - Adds output port underrun_count, 16 bits.
  - Increments on each underrun pulse and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: port and counter are absent. underrun pulse behaviour is unchanged.

Test Plan:
- Reset, pix_ce every 2nd clk, buffer empty, stream 8'hA5 then 8'h3C with active=1 -> pal_addr sequence A,5,3,C; each colour appears on red/green/blue 2 pix_ce ticks after its address; de_out follows active delayed 2 ticks.
- Palette returns 8'hE3 (R=7,G=0,B=3) -> red=FF, green=00, blue=FF. Palette returns 8'h92 (R=4,G=4,B=2) -> red=92, green=92, blue=AA.
- byte_valid held low during active=1 with UNDERRUN_INDEX=4'h0 -> pal_addr=0, one underrun pulse per pixel. With the macro defined, underrun_count reads 3 after 3 starved pixels.
- active drops while state HI with buffer holding 8'h77 -> low nibble not emitted; next active pixel is 7; red/green/blue=0 while de_out=0.
- vsync_in=1 on pix_ce with buffer valid -> byte_ready returns high the next clk; stale byte never reaches pal_addr.
- reset_n low mid-line for 1 clk -> all outputs 0 on the next clk; byte_ready 0 during reset, 1 after.
